ov7670_pixel_capture: RTL and testbench
=======================================

// Module: ov7670_pixel_capture
// PURPOSE
//  Upstream of the VGA output stage. Turns the raw OV7670 byte bus (VSYNC/HREF/D[7:0], YUV422 YUYV) into a
//  framed 8-bit grayscale pixel stream: valid strobe, x/y coordinates, start-of-frame (SOF) and end-of-line
//  (EOL) markers, and per-frame error status. Runs on the shared 25 MHz clock (camera PCLK = VGA pixel clock),
//  so there is no clock-domain crossing.
// PARAMETERS
//  H_PIXELS  640  pixels per line expected per HREF window (each pixel = 2 bytes)
//  V_LINES   480  lines expected per frame
//  Y_FIRST   1    1: byte phase 0 is the luma (Y) byte; 0: luma is the phase-1 byte
// PORTS
//  clk25       in   1   25 MHz clock; same clock drives camera XCLK/PCLK and VGA
//  reset_n     in   1   asynchronous, active-low reset
//  href        in   1   camera row-valid strobe
//  vsync_cam   in   1   camera frame strobe, active high during vertical blank
//  cam_data    in   8   camera byte bus
//  pix_valid   out  1   one-cycle strobe: pix_gray/pix_x/pix_y are valid
//  pix_gray    out  8   luma byte of the current pixel
//  pix_x       out  10  column 0..H_PIXELS-1
//  pix_y       out  9   row 0..V_LINES-1
//  sof         out  1   high together with pix_valid for pixel (0,0) of each frame
//  eol         out  1   one-cycle pulse after HREF falls on a captured line
//  frame_done  out  1   one-cycle pulse at the end of each captured frame
//  line_err    out  1   sticky per frame: some line had a pixel count != H_PIXELS or an odd byte count
//  frame_err   out  1   sticky per frame: line count != V_LINES
//  frame_cnt   out  16  number of completed frames; wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset: all outputs go to 0; state = S_SYNC; byte phase = 0; counters = 0.
//  - Input stage: href, vsync_cam and cam_data are registered once. All edge detection and decoding use the
//    registered copies.
//  - FSM:
//    - S_SYNC: wait for vsync high -> S_WAIT.
//    - S_WAIT: wait for a vsync falling edge -> S_FRAME. On entry, clear line/pixel counters and line_err/frame_err.
//    - S_FRAME: capture data. A vsync rising edge ends the frame:
//      - pulse frame_done;
//      - set frame_err if the line count != V_LINES;
//      - increment frame_cnt;
//      - go to S_WAIT.
//  - HREF is ignored in S_SYNC and S_WAIT; no pix_valid and no eol are produced there.
//  - Byte phase (S_FRAME):
//    - Cleared on an href rising edge; toggles on every href-high cycle.
//    - The luma byte, selected by Y_FIRST, is held in a register.
//    - On the phase-1 byte, pix_valid fires on the next cycle.
//    - Latency: the 2nd byte of a pixel is present on cam_data at cycle N -> pix_valid at N+2.
//  - pix_x starts at 0 on each line and increments after each emitted pixel.
//    - Pixels beyond H_PIXELS-1 are dropped (no pix_valid) and set line_err.
//  - href falling edge (S_FRAME):
//    - pulse eol one cycle after the last pix_valid;
//    - set line_err if the pixel count != H_PIXELS or the byte phase is odd (the partial pixel is discarded);
//    - increment pix_y. Lines at or beyond V_LINES are dropped (no pix_valid, no eol) and counted for frame_err.
//  - sof = pix_valid && pix_x==0 && pix_y==0.
//  - Simultaneous events:
//    - vsync rising while href is high: the frame ends and the open line is dropped (no eol); a short line
//      also sets line_err.
//    - href rising in the same cycle vsync falls: that line is not captured (capture starts with the next href).
//  - Reset asserted mid-line or mid-frame: immediate return to S_SYNC. The next SOF occurs only after a full
//    vsync high->low sequence.
//  - line_err and frame_err stay valid from frame_done until they are cleared on the next S_WAIT->S_FRAME.
// STRUCTURE
//  - Shared package cam_pkg holds:
//    - H_ACTIVE/V_ACTIVE defaults (640/480), shared with the VGA stage;
//    - the capture state enum cap_state_t {S_SYNC, S_WAIT, S_FRAME};
//    - the pixel-stream struct {valid, gray, x, y, sof}.
//  - Single module, no sub-modules: the edge detectors, byte pairing and counters are small, so they are inline.
// TESTING
//  1. Reset mid-frame, then vsync 1->0, 480 lines x 1280 bytes -> 307200 pix_valid, exactly one sof at (0,0),
//     480 eol, frame_done=1 and frame_cnt=1 on vsync rise, line_err=frame_err=0.
//  2. Byte stream Y=0x10, U=0x80, Y=0x20, V=0x80 with Y_FIRST=1 -> pix_gray 0x10 then 0x20, each pix_valid
//     2 cycles after its 2nd byte.
//  3. One line of 1281 bytes, another of 1282 bytes -> line_err=1, pix_x never exceeds 639, frame_cnt still
//     increments.
//  4. Frame of 479 lines -> frame_err=1 at frame_done; the next good frame reports frame_err=0.
//  5. vsync rises while href is high on line 200 -> no eol for that line, frame_done pulses, frame_err=1.
//  6. href toggling before the first vsync after reset -> no pix_valid, sof or eol; frame_cnt stays 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared camera/video definitions used by the capture block and the VGA stage.
// Holds the active-area defaults, the capture state encoding and the pixel-stream record.
// Pure declarations: no logic, no latency, no flow control.
package cam_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        S_SYNC,
        S_WAIT,
        S_FRAME
    } cap_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] gray;
        logic [9:0] x;
        logic [8:0] y;
        logic       sof;
    } pix_t;

endpackage

// File: rtl/ov7670_pixel_capture_if.sv
// Grayscale pixel stream plus per-frame status, from the capture block to the VGA stage.
// Wires only: timing is set entirely by the driver.
// No backpressure: the consumer must accept every pix_valid strobe.
interface ov7670_pixel_capture_if;

    logic        pix_valid;
    logic [7:0]  pix_gray;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        sof;
    logic        eol;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic [15:0] frame_cnt;

    modport master (
        output pix_valid, pix_gray, pix_x, pix_y, sof, eol,
               frame_done, line_err, frame_err, frame_cnt
    );

    modport slave (
        input  pix_valid, pix_gray, pix_x, pix_y, sof, eol,
               frame_done, line_err, frame_err, frame_cnt
    );

endinterface

// File: rtl/ov7670_pixel_capture.sv
// OV7670 YUV422 byte bus -> framed 8-bit luma stream with x/y, SOF/EOL and per-frame error flags.
// Latency: 2nd byte of a pixel on cam_data at cycle N -> pix_valid at N+2; eol one cycle after last pixel.
// No backpressure: the camera cannot be stalled, every pixel is emitted as it arrives.
module ov7670_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS = H_ACTIVE,
    parameter int V_LINES  = V_ACTIVE,
    parameter bit Y_FIRST  = 1'b1
) (
    input  logic                   clk25,
    input  logic                   reset_n,
    input  logic                   href,
    input  logic                   vsync_cam,
    input  logic [7:0]             cam_data,
    ov7670_pixel_capture_if.master pix
);

    localparam logic [9:0]  H_LIM = 10'(H_PIXELS);
    localparam logic [10:0] V_LIM = 11'(V_LINES);

    // registered camera inputs and their one-cycle-delayed copies for edge detection
    logic       href_r, vsync_r, href_d, vsync_d;
    logic [7:0] data_r;

    cap_state_t state, state_nxt;

    logic        phase;      // byte phase within the current pixel
    logic        line_act;   // a line that began inside S_FRAME is open
    logic [9:0]  pix_cnt;    // pixels emitted on the open line, saturates at H_PIXELS
    logic [10:0] line_cnt;   // completed lines this frame, saturating, may exceed V_LINES
    logic [7:0]  luma_q;

    pix_t        pix_q;
    logic        eol_q, done_q, line_err_q, frame_err_q;
    logic [15:0] frame_cnt_q;

    logic href_rise, href_fall, vsync_rise, vsync_fall;
    logic start_frame, end_frame, line_start, in_line, cur_phase, line_ok;
    logic [7:0] gray_sel;

    assign href_rise  =  href_r  & ~href_d;
    assign href_fall  = ~href_r  &  href_d;
    assign vsync_rise =  vsync_r & ~vsync_d;
    assign vsync_fall = ~vsync_r &  vsync_d;

    assign start_frame = (state == S_WAIT)  && vsync_fall;
    assign end_frame   = (state == S_FRAME) && vsync_rise;
    // a line whose href rises together with the vsync fall is still seen in S_WAIT and so skipped
    assign line_start  = (state == S_FRAME) && href_rise;
    assign in_line     = line_start || (line_act && href_r);
    assign cur_phase   = href_rise ? 1'b0 : phase;
    assign line_ok     = (line_cnt < V_LIM);
    assign gray_sel    = Y_FIRST ? luma_q : data_r;

    // capture state register
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) state <= S_SYNC;
        else          state <= state_nxt;
    end

    // frame sequencing: a full vsync high->low is needed before capture starts
    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC:  if (vsync_r)    state_nxt = S_WAIT;
            S_WAIT:  if (vsync_fall) state_nxt = S_FRAME;
            S_FRAME: if (vsync_rise) state_nxt = S_WAIT;
            default:                 state_nxt = S_SYNC;
        endcase
    end

    // input registers, byte pairing, counters, pixel/marker outputs and error flags
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            href_r      <= 1'b0;
            vsync_r     <= 1'b0;
            href_d      <= 1'b0;
            vsync_d     <= 1'b0;
            data_r      <= '0;
            phase       <= 1'b0;
            line_act    <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            luma_q      <= '0;
            pix_q       <= '0;
            eol_q       <= 1'b0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            href_r      <= href;
            vsync_r     <= vsync_cam;
            data_r      <= cam_data;
            href_d      <= href_r;
            vsync_d     <= vsync_r;
            pix_q.valid <= 1'b0;
            pix_q.sof   <= 1'b0;
            eol_q       <= 1'b0;
            done_q      <= 1'b0;

            if (start_frame) begin
                line_cnt    <= '0;
                pix_cnt     <= '0;
                line_act    <= 1'b0;
                phase       <= 1'b0;
                line_err_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end else if (end_frame) begin
                // an open line is abandoned without eol; it only counts as bad if short
                done_q      <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                frame_err_q <= (line_cnt != V_LIM);
                line_act    <= 1'b0;
                if (line_act && line_ok && pix_cnt != H_LIM)
                    line_err_q <= 1'b1;
            end else if (state == S_FRAME) begin
                if (in_line) begin
                    phase <= ~cur_phase;
                    if (!cur_phase) begin
                        luma_q <= data_r;
                    end else if (line_ok) begin
                        if (pix_cnt < H_LIM) begin
                            pix_q.valid <= 1'b1;
                            pix_q.gray  <= gray_sel;
                            pix_q.x     <= pix_cnt;
                            pix_q.y     <= line_cnt[8:0];
                            pix_q.sof   <= (pix_cnt == '0) && (line_cnt == '0);
                            pix_cnt     <= pix_cnt + 10'd1;
                        end else begin
                            line_err_q <= 1'b1;
                        end
                    end
                end
                if (line_start) begin
                    line_act <= 1'b1;
                    pix_cnt  <= '0;
                end
                if (line_act && href_fall) begin
                    line_act <= 1'b0;
                    if (line_ok) begin
                        eol_q <= 1'b1;
                        // phase still set means a dangling half pixel was discarded
                        if (pix_cnt != H_LIM || phase)
                            line_err_q <= 1'b1;
                    end
                    if (line_cnt != 11'h7FF)
                        line_cnt <= line_cnt + 11'd1;
                end
            end
        end
    end

    assign pix.pix_valid  = pix_q.valid;
    assign pix.pix_gray   = pix_q.gray;
    assign pix.pix_x      = pix_q.x;
    assign pix.pix_y      = pix_q.y;
    assign pix.sof        = pix_q.sof;
    assign pix.eol        = eol_q;
    assign pix.frame_done = done_q;
    assign pix.line_err   = line_err_q;
    assign pix.frame_err  = frame_err_q;
    assign pix.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture on a reduced 8x6 frame.
// Reference model derives pixels, eol timing and error flags from per-line byte counts.
// Stream has no backpressure; the monitor records every strobe.
module tb_ov7670_pixel_capture;

    localparam int H = 8;
    localparam int V = 6;

    typedef struct packed {
        logic [7:0]  gray;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic [31:0] cyc;
    } px_t;

    logic       clk25 = 1'b0;
    logic       reset_n;
    logic       href;
    logic       vsync_cam;
    logic [7:0] cam_data;

    ov7670_pixel_capture_if pif ();

    ov7670_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(1'b1)) dut (
        .clk25     (clk25),
        .reset_n   (reset_n),
        .href      (href),
        .vsync_cam (vsync_cam),
        .cam_data  (cam_data),
        .pix       (pif)
    );

    always #20 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // observed stream
    px_t  obs_pix[$];
    int   obs_eol[$];
    int   done_cnt, sof_cnt, max_x;
    logic obs_le, obs_fe;

    // reference model state
    px_t         exp_pix[$];
    int          exp_eol[$];
    logic        exp_line_err, exp_frame_err;
    logic [15:0] exp_frame_cnt = '0;
    int          line_len[$];
    logic [7:0]  preset[$];
    int          abort_at = -1;
    int          abort_bytes = 0;

    always @(negedge clk25) begin : monitor
        px_t p;
        if (pif.pix_valid) begin
            p.gray = pif.pix_gray; p.x = pif.pix_x; p.y = pif.pix_y;
            p.sof = pif.sof; p.cyc = 32'(cyc);
            obs_pix.push_back(p);
            if (int'(pif.pix_x) > max_x) max_x = int'(pif.pix_x);
        end
        if (pif.sof) sof_cnt++;
        if (pif.eol) obs_eol.push_back(cyc);
        if (pif.frame_done) begin
            done_cnt++;
            obs_le = pif.line_err;
            obs_fe = pif.frame_err;
        end
    end

    task automatic drive(input logic h, input logic v, input logic [7:0] d);
        href = h; vsync_cam = v; cam_data = d;
        @(posedge clk25); #1;
    endtask

    function automatic void clear_obs();
        obs_pix.delete(); obs_eol.delete();
        done_cnt = 0; sof_cnt = 0; max_x = 0;
        obs_le = 1'bx; obs_fe = 1'bx;
    endfunction

    function automatic string pix_diff();
        if (obs_pix.size() != exp_pix.size())
            return $sformatf("pixel count %0d, want %0d", obs_pix.size(), exp_pix.size());
        foreach (exp_pix[i])
            if (obs_pix[i] !== exp_pix[i])
                return $sformatf("pixel %0d got g=%h x=%0d y=%0d sof=%b cyc=%0d, want g=%h x=%0d y=%0d sof=%b cyc=%0d",
                    i, obs_pix[i].gray, obs_pix[i].x, obs_pix[i].y, obs_pix[i].sof, obs_pix[i].cyc,
                    exp_pix[i].gray, exp_pix[i].x, exp_pix[i].y, exp_pix[i].sof, exp_pix[i].cyc);
        return "";
    endfunction

    function automatic string eol_diff();
        if (obs_eol.size() != exp_eol.size())
            return $sformatf("eol count %0d, want %0d", obs_eol.size(), exp_eol.size());
        foreach (exp_eol[i])
            if (obs_eol[i] != exp_eol[i])
                return $sformatf("eol %0d at cycle %0d, want %0d", i, obs_eol[i], exp_eol[i]);
        return "";
    endfunction

    task automatic set_lines(input int n, input int len);
        line_len.delete();
        for (int i = 0; i < n; i++) line_len.push_back(len);
        abort_at = -1;
    endtask

    // vsync pulse, lines per line_len (optionally cut by a vsync rise), closing vsync rise
    task automatic send_frame();
        int completed, n, bc, last_bc;
        logic [7:0] b, first;
        px_t p;
        clear_obs(); exp_pix.delete(); exp_eol.delete();
        exp_line_err = 1'b0; completed = 0; last_bc = 0; first = '0;
        repeat (4) drive(1'b0, 1'b1, 8'h00);
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < line_len.size(); l++) begin
            n = (l == abort_at) ? abort_bytes : line_len[l];
            for (int k = 0; k < n; k++) begin
                b  = (preset.size() > 0) ? preset.pop_front() : 8'($urandom);
                bc = cyc;
                if (k % 2 == 0) begin
                    first = b;
                end else if (l < V && k / 2 < H) begin
                    p.gray = first; p.x = 10'(k / 2); p.y = 9'(l);
                    p.sof = (k / 2 == 0) && (l == 0); p.cyc = 32'(bc + 2);
                    exp_pix.push_back(p);
                end
                drive(1'b1, 1'b0, b);
                last_bc = bc;
            end
            if (l == abort_at) begin
                if (l < V && n / 2 != H) exp_line_err = 1'b1;
                repeat (3) drive(1'b1, 1'b1, 8'($urandom));
                break;
            end
            if (l < V) begin
                exp_eol.push_back(last_bc + 3);
                if (n != 2 * H) exp_line_err = 1'b1;
            end
            completed++;
            repeat ($urandom_range(1, 4)) drive(1'b0, 1'b0, 8'h00);
        end
        repeat (6) drive(1'b0, 1'b1, 8'h00);
        exp_frame_err = (completed != V);
        exp_frame_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'($urandom), 1'($urandom), 8'($urandom));
        vectors++;
        if ({pif.pix_valid, pif.pix_gray, pif.pix_x, pif.pix_y, pif.sof} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset.stream: got %h, want 0", {pif.pix_valid, pif.pix_gray, pif.pix_x, pif.pix_y, pif.sof});
        end
        vectors++;
        if ({pif.eol, pif.frame_done, pif.line_err, pif.frame_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset.flags: got %b, want 0000", {pif.eol, pif.frame_done, pif.line_err, pif.frame_err});
        end
        vectors++;
        if (pif.frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset.frame_cnt: got %0d, want 0", pif.frame_cnt);
        end
        drive(1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        exp_frame_cnt = '0;
        clear_obs();
    endtask

    task automatic test_href_without_vsync();
        clear_obs();
        for (int l = 0; l < 3; l++) begin
            repeat (2 * H) drive(1'b1, 1'b0, 8'($urandom));
            repeat (3) drive(1'b0, 1'b0, 8'h00);
        end
        // vsync high only: still waiting for its falling edge
        for (int l = 0; l < 2; l++) begin
            repeat (2 * H) drive(1'b1, 1'b1, 8'($urandom));
            repeat (3) drive(1'b0, 1'b1, 8'h00);
        end
        vectors++;
        if (obs_pix.size() != 0 || sof_cnt != 0) begin
            miscompares++;
            $display("FAIL no_vsync.pixels: got %0d pixels %0d sof, want 0 0", obs_pix.size(), sof_cnt);
        end
        vectors++;
        if (obs_eol.size() != 0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL no_vsync.markers: got %0d eol %0d done, want 0 0", obs_eol.size(), done_cnt);
        end
        vectors++;
        if (pif.frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL no_vsync.frame_cnt: got %0d, want 0", pif.frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        repeat (4) drive(1'b0, 1'b1, 8'h00);
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        repeat (2 * H) drive(1'b1, 1'b0, 8'($urandom));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        repeat (H) drive(1'b1, 1'b0, 8'($urandom));
        reset_n = 1'b0;
        clear_obs();
        repeat (2) drive(1'b1, 1'b0, 8'($urandom));
        reset_n = 1'b1;
        exp_frame_cnt = '0;
        repeat (4) drive(1'b1, 1'b0, 8'($urandom));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        repeat (2 * H) drive(1'b1, 1'b0, 8'($urandom));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        vectors++;
        if (obs_pix.size() != 0 || obs_eol.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset.quiet: got %0d pixels %0d eol after reset, want 0 0", obs_pix.size(), obs_eol.size());
        end
        set_lines(V, 2 * H);
        send_frame();
        vectors++;
        if (pix_diff() != "") begin miscompares++; $display("FAIL mid_reset.pixels: %s", pix_diff()); end
        vectors++;
        if (eol_diff() != "") begin miscompares++; $display("FAIL mid_reset.eol: %s", eol_diff()); end
        vectors++;
        if (sof_cnt != 1) begin miscompares++; $display("FAIL mid_reset.sof: got %0d, want 1", sof_cnt); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL mid_reset.done: got %0d, want 1", done_cnt); end
        vectors++;
        if ({obs_le, obs_fe} !== 2'b00) begin miscompares++; $display("FAIL mid_reset.errs: got %b, want 00", {obs_le, obs_fe}); end
        vectors++;
        if (pif.frame_cnt !== 16'd1) begin miscompares++; $display("FAIL mid_reset.frame_cnt: got %0d, want 1", pif.frame_cnt); end
    endtask

    task automatic test_yuv_order();
        preset = '{8'h10, 8'h80, 8'h20, 8'h80};
        set_lines(V, 2 * H);
        send_frame();
        vectors++;
        if (obs_pix.size() < 2 || obs_pix[0].gray !== 8'h10 || obs_pix[1].gray !== 8'h20) begin
            miscompares++;
            $display("FAIL yuv.gray: got %0d pixels first %h second %h, want 10 20", obs_pix.size(),
                     obs_pix.size() > 0 ? obs_pix[0].gray : 8'h00, obs_pix.size() > 1 ? obs_pix[1].gray : 8'h00);
        end
        vectors++;
        if (pix_diff() != "") begin miscompares++; $display("FAIL yuv.pixels: %s", pix_diff()); end
        vectors++;
        if (pif.frame_cnt !== exp_frame_cnt) begin miscompares++; $display("FAIL yuv.frame_cnt: got %0d, want %0d", pif.frame_cnt, exp_frame_cnt); end
    endtask

    task automatic test_long_lines();
        set_lines(V, 2 * H);
        line_len[1] = 2 * H + 1;
        line_len[3] = 2 * H + 2;
        send_frame();
        vectors++;
        if (pix_diff() != "") begin miscompares++; $display("FAIL long.pixels: %s", pix_diff()); end
        vectors++;
        if (eol_diff() != "") begin miscompares++; $display("FAIL long.eol: %s", eol_diff()); end
        vectors++;
        if (max_x > H - 1) begin miscompares++; $display("FAIL long.max_x: got %0d, want <= %0d", max_x, H - 1); end
        vectors++;
        if ({obs_le, obs_fe} !== {exp_line_err, exp_frame_err}) begin
            miscompares++; $display("FAIL long.errs: got %b, want %b", {obs_le, obs_fe}, {exp_line_err, exp_frame_err});
        end
        vectors++;
        if (pif.frame_cnt !== exp_frame_cnt) begin miscompares++; $display("FAIL long.frame_cnt: got %0d, want %0d", pif.frame_cnt, exp_frame_cnt); end
    endtask

    task automatic test_short_frame();
        set_lines(V - 1, 2 * H);
        send_frame();
        vectors++;
        if (eol_diff() != "") begin miscompares++; $display("FAIL short.eol: %s", eol_diff()); end
        vectors++;
        if ({obs_le, obs_fe} !== {exp_line_err, exp_frame_err}) begin
            miscompares++; $display("FAIL short.errs: got %b, want %b", {obs_le, obs_fe}, {exp_line_err, exp_frame_err});
        end
        set_lines(V, 2 * H);
        send_frame();
        vectors++;
        if ({obs_le, obs_fe} !== {exp_line_err, exp_frame_err}) begin
            miscompares++; $display("FAIL short.recover: got %b, want %b", {obs_le, obs_fe}, {exp_line_err, exp_frame_err});
        end
        vectors++;
        if (pif.frame_cnt !== exp_frame_cnt) begin miscompares++; $display("FAIL short.frame_cnt: got %0d, want %0d", pif.frame_cnt, exp_frame_cnt); end
    endtask

    task automatic test_vsync_abort();
        set_lines(V, 2 * H);
        abort_at    = 3;
        abort_bytes = 6;
        send_frame();
        vectors++;
        if (pix_diff() != "") begin miscompares++; $display("FAIL abort.pixels: %s", pix_diff()); end
        vectors++;
        if (eol_diff() != "") begin miscompares++; $display("FAIL abort.eol: %s", eol_diff()); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL abort.done: got %0d, want 1", done_cnt); end
        vectors++;
        if ({obs_le, obs_fe} !== {exp_line_err, exp_frame_err}) begin
            miscompares++; $display("FAIL abort.errs: got %b, want %b", {obs_le, obs_fe}, {exp_line_err, exp_frame_err});
        end
    endtask

    task automatic test_back_to_back();
        int nl;
        int lens[7];
        lens = '{2 * H - 2, 2 * H - 1, 2 * H, 2 * H, 2 * H, 2 * H + 1, 2 * H + 3};
        for (int f = 0; f < 4; f++) begin
            nl = V - 1 + int'($urandom_range(0, 2));
            line_len.delete();
            for (int l = 0; l < nl; l++) line_len.push_back(lens[$urandom_range(0, 6)]);
            abort_at    = (f == 2) ? int'($urandom_range(0, nl - 1)) : -1;
            abort_bytes = 2 * int'($urandom_range(1, H - 1));
            send_frame();
            vectors++;
            if (pix_diff() != "") begin miscompares++; $display("FAIL b2b[%0d].pixels: %s", f, pix_diff()); end
            vectors++;
            if (eol_diff() != "") begin miscompares++; $display("FAIL b2b[%0d].eol: %s", f, eol_diff()); end
            vectors++;
            if (done_cnt != 1) begin miscompares++; $display("FAIL b2b[%0d].done: got %0d, want 1", f, done_cnt); end
            vectors++;
            if ({obs_le, obs_fe} !== {exp_line_err, exp_frame_err}) begin
                miscompares++; $display("FAIL b2b[%0d].errs: got %b, want %b", f, {obs_le, obs_fe}, {exp_line_err, exp_frame_err});
            end
            vectors++;
            if (pif.frame_cnt !== exp_frame_cnt) begin
                miscompares++; $display("FAIL b2b[%0d].frame_cnt: got %0d, want %0d", f, pif.frame_cnt, exp_frame_cnt);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; href = 1'b0; vsync_cam = 1'b0; cam_data = 8'h00;
        clear_obs();
        @(posedge clk25); #1;
        test_reset();
        test_href_without_vsync();
        test_reset_mid_frame();
        test_yuv_order();
        test_long_lines();
        test_short_frame();
        test_vsync_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
